// File: rtl/regfile_pkg.sv
// Shared constants and types for the datapath register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Optional feature macro used by register_file: REGFILE_BYPASS_EN.
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_wdec.sv
// One-hot write-enable decoder for the register file; entry 0 never enabled.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the write port always accepts.
//
// Ports:
//   wrEn      - write request (RW)
//   wrAddr    - destination register address (RD)
//   wrOneHot  - per-register write enable, bit 0 forced low
module regfile_wdec
   import regfile_pkg::*;
(
   input  logic                wrEn,
   input  reg_addr_t           wrAddr,
   output logic [NUM_REGS-1:0] wrOneHot
);

   always_comb begin
      wrOneHot = '0;
      if (wrEn) begin
         wrOneHot[wrAddr] = 1'b1;
      end
      // Register 0 is the constant-zero register; writes to it are dropped.
      wrOneHot[0] = 1'b0;
   end

endmodule : regfile_wdec

// File: rtl/register_file.sv
// 32x32 register file, two combinational read ports, one synchronous write port.
// Latency: reads zero cycles; writes visible after one rising Clk edge.
// Backpressure: none; a write is taken on every edge with RW=1.
//
// Ports:
//   Clk, Reset_n   - clock, asynchronous active-low reset (clears all registers)
//   RS, RT         - read addresses; dataRS, dataRT - read data
//   RD, dataRD, RW - write address, write data, write enable
// Build option: define REGFILE_BYPASS_EN to forward dataRD to a read port
// whose address matches a pending write (RD != 0) before the edge.
module register_file
   import regfile_pkg::*;
(
   input  logic      Clk,
   input  logic      Reset_n,
   output reg_data_t dataRS,
   output reg_data_t dataRT,
   input  reg_addr_t RD,
   input  reg_addr_t RS,
   input  reg_addr_t RT,
   input  reg_data_t dataRD,
   input  logic      RW
);

   reg_data_t           regs [NUM_REGS];
   logic [NUM_REGS-1:0] wrOneHot;

   regfile_wdec uWdec (
      .wrEn     (RW),
      .wrAddr   (RD),
      .wrOneHot (wrOneHot)
   );

   // Entry 0 is reset to zero and its enable is tied low by the decoder,
   // so it reads as zero through the ordinary mux without a special case.
   for (genvar i = 0; i < NUM_REGS; i++) begin : gReg
      always_ff @(posedge Clk or negedge Reset_n) begin
         if (!Reset_n) begin
            regs[i] <= '0;
         end else if (wrOneHot[i]) begin
            regs[i] <= dataRD;
         end
      end
   end

`ifdef REGFILE_BYPASS_EN
   // Forwarding is held off during reset so the read ports show zero there,
   // matching the cleared storage.
   logic fwdLive;
   assign fwdLive = Reset_n && RW && (RD != '0);

   assign dataRS = (fwdLive && (RS == RD)) ? dataRD : regs[RS];
   assign dataRT = (fwdLive && (RT == RD)) ? dataRD : regs[RT];
`else
   assign dataRS = regs[RS];
   assign dataRT = regs[RT];
`endif

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file with hand-computed expectations.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_register_file;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [31:0] dataRS, dataRT;
   logic [4:0]  RD, RS, RT;
   logic [31:0] dataRD;
   logic        RW;

   int compared   = 0;
   int mismatched = 0;

   register_file dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .dataRS  (dataRS),
      .dataRT  (dataRT),
      .RD      (RD),
      .RS      (RS),
      .RT      (RT),
      .dataRD  (dataRD),
      .RW      (RW)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        rw;
      logic [4:0]  rd;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] d;
      logic [31:0] expRs;
      logic [31:0] expRt;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rw, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [31:0] d);
      RW = rw; RD = rd; RS = rs; RT = rt; dataRD = d;
   endtask

   initial begin
      logic [31:0] expPre;

      // Each row: inputs applied after a falling edge, outputs checked before
      // the following rising edge, which then commits any write.
      // No row with rw=1 reads the register it writes, so rows hold in both builds.
      vecs[0]  = '{1'b1, 5'd5,  5'd0,  5'd0,  32'd10,        32'd0,         32'd0};
      vecs[1]  = '{1'b0, 5'd0,  5'd5,  5'd6,  32'd0,         32'd10,        32'd0};
      vecs[2]  = '{1'b1, 5'd6,  5'd5,  5'd0,  32'd5,         32'd10,        32'd0};
      vecs[3]  = '{1'b0, 5'd0,  5'd5,  5'd6,  32'd0,         32'd10,        32'd5};
      vecs[4]  = '{1'b1, 5'd7,  5'd5,  5'd6,  32'd15,        32'd10,        32'd5};
      vecs[5]  = '{1'b0, 5'd0,  5'd7,  5'd7,  32'd0,         32'd15,        32'd15};
      vecs[6]  = '{1'b1, 5'd0,  5'd7,  5'd0,  32'd100,       32'd15,        32'd0};
      vecs[7]  = '{1'b1, 5'd0,  5'd0,  5'd0,  32'd100,       32'd0,         32'd0};
      vecs[8]  = '{1'b0, 5'd5,  5'd0,  5'd0,  32'hDEADBEEF,  32'd0,         32'd0};
      vecs[9]  = '{1'b0, 5'd5,  5'd5,  5'd0,  32'hDEADBEEF,  32'd10,        32'd0};
      vecs[10] = '{1'b1, 5'd31, 5'd1,  5'd2,  32'hA5A5A5A5,  32'd0,         32'd0};
      vecs[11] = '{1'b0, 5'd0,  5'd31, 5'd5,  32'd0,         32'hA5A5A5A5,  32'd10};
      vecs[12] = '{1'b1, 5'd1,  5'd31, 5'd31, 32'hFFFFFFFF,  32'hA5A5A5A5,  32'hA5A5A5A5};
      vecs[13] = '{1'b0, 5'd0,  5'd1,  5'd0,  32'd0,         32'hFFFFFFFF,  32'd0};

      // Reset state
      Reset_n = 1'b0;
      drive(1'b0, 5'd0, 5'd5, 5'd31, 32'd0);
      #1;
      check("reset.RS", dataRS, 32'd0);
      check("reset.RT", dataRT, 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         @(negedge Clk);
         drive(vecs[i].rw, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].d);
         #1;
         check($sformatf("vec%0d.RS", i), dataRS, vecs[i].expRs);
         check($sformatf("vec%0d.RT", i), dataRT, vecs[i].expRt);
      end

      // Combinational read-address change with no clock edge in between
      @(negedge Clk);
      drive(1'b0, 5'd0, 5'd5, 5'd0, 32'd0);
      #1;
      check("comb.RS5", dataRS, 32'd10);
      RS = 5'd6;
      #1;
      check("comb.RS6", dataRS, 32'd5);
      RS = 5'd8;
      #1;
      check("comb.RS8_unwritten", dataRS, 32'd0);

      // Same-cycle read of the register being written
`ifdef REGFILE_BYPASS_EN
      expPre = 32'h1234;
`else
      expPre = 32'h0;
`endif
      @(negedge Clk);
      drive(1'b1, 5'd9, 5'd9, 5'd9, 32'h1234);
      #1;
      check("wr9.pre.RS", dataRS, expPre);
      check("wr9.pre.RT", dataRT, expPre);
      @(posedge Clk);
      #1;
      check("wr9.post.RS", dataRS, 32'h1234);
      RW = 1'b0;
      #1;
      check("wr9.hold.RT", dataRT, 32'h1234);

      // Pending write to register 0 is never forwarded
      @(negedge Clk);
      drive(1'b1, 5'd0, 5'd0, 5'd0, 32'h55);
      #1;
      check("wr0.pre.RS", dataRS, 32'd0);
      @(posedge Clk);
      #1;
      check("wr0.post.RT", dataRT, 32'd0);

      // Mid-run reset away from any edge, with a write pending; reset wins
      @(negedge Clk);
      drive(1'b1, 5'd10, 5'd5, 5'd31, 32'd77);
      #2;
      Reset_n = 1'b0;
      #1;
      check("midreset.RS5", dataRS, 32'd0);
      check("midreset.RT31", dataRT, 32'd0);
      @(posedge Clk);
      #1;
      RS = 5'd10;
      RT = 5'd9;
      #1;
      check("midreset.RS10", dataRS, 32'd0);
      check("midreset.RT9", dataRT, 32'd0);
      @(negedge Clk);
      RW = 1'b0;
      Reset_n = 1'b1;
      #1;
      check("postreset.RS10", dataRS, 32'd0);
      @(posedge Clk);
      #1;
      check("postreset.RT9", dataRT, 32'd0);

      // Writes resume normally after reset
      @(negedge Clk);
      drive(1'b1, 5'd3, 5'd0, 5'd0, 32'hCAFEF00D);
      @(negedge Clk);
      drive(1'b0, 5'd0, 5'd3, 5'd10, 32'd0);
      #1;
      check("resume.RS3", dataRS, 32'hCAFEF00D);
      check("resume.RT10", dataRT, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_register_file

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose register file for the ICOM4215 datapath: 32 registers × 32 bits.
- Two asynchronous read ports (RS, RT) feed ALU operands.
- One synchronous write port (RD) takes the writeback result.
- Register 0 is hard-wired to zero (MIPS/ARM-style $zero convention).

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, register address width; number of registers NUM_REGS = 2**ADDR_W (32).

Ports:
- Clk  input  1  system clock; all writes occur on its rising edge.
- Reset_n  input  1  asynchronous, active-low reset; clears every register.
- dataRS  output  DATA_W  contents of register addressed by RS.
- dataRT  output  DATA_W  contents of register addressed by RT.
- RD  input  ADDR_W  write (destination) register address.
- RS  input  ADDR_W  read port A address.
- RT  input  ADDR_W  read port B address.
- dataRD  input  DATA_W  write data.
- RW  input  1  write enable: 1 = write dataRD into RD on the next rising Clk edge; 0 = no write.

Behaviour:
- One clock (Clk); reset is asynchronous and active-low (Reset_n).
- Reset_n=0: all 32 registers clear to 0 immediately, independent of Clk. Consequently dataRS=dataRT=0 during reset. Registers hold 0 until written after Reset_n deasserts.
- Write: on posedge Clk with Reset_n=1 and RW=1, reg[RD] <= dataRD. The value is visible on read ports after that edge (1-edge write latency).
- RW=0: no register changes, regardless of RD or dataRD.
- Writes to RD=0 are discarded; reg[0] always reads 0.
- Reads: purely combinational. dataRS = reg[RS] and dataRT = reg[RT] follow address or register changes within the same delta cycle; there is no read clock or latency.
- RS and RT may address the same register; both ports then show identical data.
- Same-cycle read of a register being written (default build): read ports return the old value until the edge, then the new value.
- Reset asserted while RW=1: reset wins; no write takes effect during or at the deassertion edge while Reset_n=0.
- Unknown/X addresses are not required to be handled; outputs are don't-care.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When RW=1, RD!=0 and RS==RD (resp. RT==RD), dataRS (resp. dataRT) combinationally returns dataRD before the clock edge. RD=0 is never forwarded; it still reads 0.
- Undefined: no forwarding; behaviour exactly as in Behaviour.

Decomposition:
- Package regfile_pkg holds:
  - constants DATA_W=32, ADDR_W=5, NUM_REGS=32;
  - typedefs reg_addr_t [ADDR_W-1:0] and reg_data_t [DATA_W-1:0].
- Sub-module regfile_wdec: ADDR_W-to-NUM_REGS one-hot write-enable decoder gated by RW, with bit 0 forced low. Instantiated once.
- Storage and read muxes stay in register_file.

Test Plan:
- Reset: pulse Reset_n low mid-run after writes -> all reads return 0 immediately, without waiting for a Clk edge.
- Write and read via RS: RD=5, dataRD=10, RW=1 for one edge; then RW=0, RS=5 -> dataRS=10. Changing RS to 6 (unwritten) -> dataRS=0 combinationally.
- Write and read via RT: RD=6, dataRD=5, RW=1; then RW=0, RT=6 -> dataRT=5. Same-cycle sum dataRS+dataRT=15 written to RD=7; then RS=RT=7 -> both read 15.
- Zero register: RD=0, dataRD=100, RW=1 for several edges; then RT=0 -> dataRT=0.
- Write disable: RW=0, RD=5, dataRD=0xDEADBEEF across edges -> reg 5 still reads 10.
- Bypass (REGFILE_BYPASS_EN defined): RW=1, RD=9, dataRD=0x1234, RS=9, sampled before the edge -> dataRS=0x1234. Without the macro -> dataRS=0 until the edge.
